// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM states, data-width encodings and parity select.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

   localparam int DIV_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } rx_state_t;

   localparam logic [1:0] BITS_5 = 2'b00;
   localparam logic [1:0] BITS_6 = 2'b01;
   localparam logic [1:0] BITS_7 = 2'b10;
   localparam logic [1:0] BITS_8 = 2'b11;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic [3:0] data_bits(input logic [1:0] sel);
      case (sel)
         BITS_5:  return 4'd5;
         BITS_6:  return 4'd6;
         BITS_7:  return 4'd7;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for idle-high async inputs (RX, CTS, DSR); resets to 1.
// Latency 2 cycles; no flow control.
module uart_sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled 5-8 data bits, optional parity, one stop bit.
// Character appears 1 cycle after the stop sample; an untaken character causes overrun (new frame dropped, err set).
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic                 cfg_en_i,
   input  logic [DIV_WIDTH-1:0] cfg_div_i,
   input  logic [1:0]           cfg_bits_i,
   input  logic                 cfg_parity_en_i,
   input  logic                 cfg_parity_odd_i,
   output logic [7:0]           rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 err_o,
   input  logic                 err_clr_i,
   output logic                 busy_o
);

   rx_state_t            r_state;
   rx_state_t            w_next;
   logic                 w_rxs;
   logic [DIV_WIDTH-1:0] r_cnt;
   logic [DIV_WIDTH-1:0] w_target;
   logic                 w_sample;
   logic [2:0]           r_idx;
   logic [7:0]           r_shift;
   logic                 r_perr;
   logic [7:0]           r_data;
   logic                 r_valid;
   logic                 r_err;
   logic [3:0]           w_nbits;
   logic                 w_last_bit;
   logic                 w_busy;
   logic                 w_frame_done;
   logic                 w_can_load;
   logic                 w_err_evt;

   uart_sync_2ff u_sync (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_d   (rx_i),
      .o_q   (w_rxs)
   );

   assign w_nbits    = data_bits(cfg_bits_i);
   assign w_target   = (r_state == ST_START) ? (cfg_div_i >> 1) : cfg_div_i;
   assign w_sample   = (r_cnt == w_target);
   // >= rather than == so a width change mid-frame cannot strand the FSM in DATA
   assign w_last_bit = ({1'b0, r_idx} >= (w_nbits - 4'd1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (!cfg_en_i) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:      if (!w_rxs) w_next = ST_START;
            ST_START:     if (w_sample) w_next = w_rxs ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_sample && w_last_bit)
                             w_next = cfg_parity_en_i ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (w_sample) w_next = ST_STOP;
            ST_STOP:      if (w_sample) w_next = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (w_rxs) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy       = (r_state != ST_IDLE);
      w_frame_done = cfg_en_i && (r_state == ST_STOP) && w_sample;
      w_can_load   = !r_valid || rx_ready_i;
      w_err_evt    = w_frame_done && (r_perr || !w_rxs || !w_can_load);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_perr  <= 1'b0;
      end else begin
         if (r_state == ST_IDLE || r_state == ST_WAIT_HIGH || w_sample || !cfg_en_i) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         // Cleared in IDLE so narrow characters come out with zero upper bits
         if (r_state == ST_IDLE) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
         end else if (w_sample) begin
            case (r_state)
               ST_DATA: begin
                  r_shift[r_idx] <= w_rxs;
                  r_idx          <= r_idx + 3'd1;
               end
               ST_PARITY: r_perr <= (w_rxs != ((^r_shift) ^ cfg_parity_odd_i));
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_frame_done && w_can_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (rx_ready_i) begin
            r_valid <= 1'b0;
         end

         if (w_err_evt) begin
            r_err <= 1'b1;
         end else if (err_clr_i) begin
            r_err <= 1'b0;
         end
      end
   end

   assign rx_data_o  = r_data;
   assign rx_valid_o = r_valid;
   assign err_o      = r_err;
   assign busy_o     = w_busy;

endmodule
